// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman stage sequencer: FSM states,
// stage_id codes, and helpers mapping a state to its stage code and successor.
package huffman_pkg;

    localparam int NUM_SYM = 6;
    localparam int CNT_MAX = 255;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_READ    = 4'd1,
        S_CNT_OUT = 4'd2,
        S_COMB1   = 4'd3,
        S_COMB2   = 4'd4,
        S_COMB3   = 4'd5,
        S_COMB4   = 4'd6,
        S_SPLIT4  = 4'd7,
        S_SPLIT3  = 4'd8,
        S_SPLIT2  = 4'd9,
        S_SPLIT1  = 4'd10,
        S_DONE    = 4'd11
    } state_t;

    localparam logic [3:0] STG_NONE = 4'd0;
    localparam logic [3:0] STG_C1   = 4'd1;
    localparam logic [3:0] STG_C2   = 4'd2;
    localparam logic [3:0] STG_C3   = 4'd3;
    localparam logic [3:0] STG_C4   = 4'd4;
    localparam logic [3:0] STG_S4   = 4'd5;
    localparam logic [3:0] STG_S3   = 4'd6;
    localparam logic [3:0] STG_S2   = 4'd7;
    localparam logic [3:0] STG_S1   = 4'd8;

    function automatic logic [3:0] stage_code(input state_t s);
        case (s)
            S_COMB1:  return STG_C1;
            S_COMB2:  return STG_C2;
            S_COMB3:  return STG_C3;
            S_COMB4:  return STG_C4;
            S_SPLIT4: return STG_S4;
            S_SPLIT3: return STG_S3;
            S_SPLIT2: return STG_S2;
            S_SPLIT1: return STG_S1;
            default:  return STG_NONE;
        endcase
    endfunction

    // Combine stages run C1..C4, split stages unwind C4..C1, then DONE.
    function automatic state_t next_stage(input state_t s);
        case (s)
            S_COMB1:  return S_COMB2;
            S_COMB2:  return S_COMB3;
            S_COMB3:  return S_COMB4;
            S_COMB4:  return S_SPLIT4;
            S_SPLIT4: return S_SPLIT3;
            S_SPLIT3: return S_SPLIT2;
            S_SPLIT2: return S_SPLIT1;
            S_SPLIT1: return S_DONE;
            default:  return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/sym_histogram.sv
// Six saturating symbol counters plus a sticky illegal-symbol flag.
// start reloads the histogram from a single sample; count_en accumulates.
module sym_histogram
    import huffman_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      count_en,
    input  logic [7:0]                sym,
    output logic [NUM_SYM-1:0][7:0]   cnt,
    output logic                      sym_err
);

    logic legal;
    assign legal = (sym >= 8'd1) && (sym <= 8'(NUM_SYM));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            sym_err <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                cnt[i] <= (sym == 8'(i + 1)) ? 8'd1 : 8'd0;
            end
            sym_err <= !legal;
        end else if (count_en) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                if ((sym == 8'(i + 1)) && (cnt[i] != 8'(CNT_MAX))) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
            if (!legal) begin
                sym_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/huffman_seq.sv
// Frame reader and eight-stage sequencer for the Huffman datapath.
// All strobes are registered from the next state, so they align with the state.
module huffman_seq
    import huffman_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       gray_valid,
    input  logic [7:0] gray_data,
    input  logic       stage_done,
    output logic       CNT_valid,
    output logic [7:0] CNT1,
    output logic [7:0] CNT2,
    output logic [7:0] CNT3,
    output logic [7:0] CNT4,
    output logic [7:0] CNT5,
    output logic [7:0] CNT6,
    output logic       stage_go,
    output logic [3:0] stage_id,
    output logic       code_valid,
    output logic       busy,
    output logic       sym_err,
    output logic [3:0] state_dbg
);

    state_t                    state, state_next;
    logic [NUM_SYM-1:0][7:0]   cnt;

    sym_histogram u_hist (
        .clk      (clk),
        .reset    (reset),
        .start    ((state == S_IDLE) && gray_valid),
        .count_en ((state == S_READ) && gray_valid),
        .sym      (gray_data),
        .cnt      (cnt),
        .sym_err  (sym_err)
    );

    assign CNT1      = cnt[0];
    assign CNT2      = cnt[1];
    assign CNT3      = cnt[2];
    assign CNT4      = cnt[3];
    assign CNT5      = cnt[4];
    assign CNT6      = cnt[5];
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // stage_go marks the first cycle of a stage, when stage_done is not yet trusted.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (gray_valid) state_next = S_READ;
            S_READ:    if (!gray_valid) state_next = S_CNT_OUT;
            S_CNT_OUT: state_next = S_COMB1;
            S_DONE:    state_next = S_IDLE;
            default:   if (!stage_go && stage_done) state_next = next_stage(state);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            CNT_valid  <= 1'b0;
            stage_go   <= 1'b0;
            stage_id   <= STG_NONE;
            code_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            CNT_valid  <= (state_next == S_CNT_OUT);
            stage_go   <= (state_next != state) && (stage_code(state_next) != STG_NONE);
            stage_id   <= stage_code(state_next);
            code_valid <= (state_next == S_DONE);
            busy       <= (state_next != S_IDLE);
        end
    end

endmodule

// File: doc/huffman_seq.md
HUFFMAN_SEQ -- requirements
Module: huffman_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port gray_valid, input, 1, marks a valid symbol on gray_data this cycle.
REQ-004 SHALL have port gray_data, input, 8, symbol; legal values 1..6.
REQ-005 SHALL have port stage_done, input, 1, datapath completion of the current stage.
REQ-006 SHALL have port CNT_valid, output, 1, one-cycle pulse when CNT1..CNT6 are final.
REQ-007 SHALL have ports CNT1..CNT6, output, 8 each, occurrence count of symbols 1..6.
REQ-008 SHALL have port stage_go, output, 1, one-cycle start strobe to the datapath.
REQ-009 SHALL have port stage_id, output, 4, current stage: 0 none, 1..4 combine C1..C4, 5..8 split C4..C1.
REQ-010 SHALL have port code_valid, output, 1, one-cycle pulse when all eight stages have completed.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port sym_err, output, 1, sticky flag for an illegal symbol in the current frame.

Function
REQ-013 SHALL implement states IDLE, READ, CNT_OUT, COMB1..COMB4, SPLIT4..SPLIT1, DONE.
REQ-014 IDLE: gray_valid=1 -> READ; the same-cycle sample is counted; CNT1..CNT6 load 0 except the matching symbol, which loads 1; sym_err loads the legality result of that sample.
REQ-015 READ: each cycle with gray_valid=1 and gray_data in 1..6 increments the matching CNTn at the next edge.
REQ-016 CNTn SHALL saturate at 255; increments at 255 are dropped.
REQ-017 gray_valid=1 with gray_data outside 1..6 SHALL change no counter and SHALL set sym_err.
REQ-018 READ with gray_valid=0 -> CNT_OUT on the next edge; no minimum frame length applies.
REQ-019 CNT_OUT SHALL last exactly one cycle with CNT_valid=1, then go to COMB1.
REQ-020 On entry to each COMBk/SPLITk, stage_go=1 for exactly that first cycle, and stage_id holds that stage's code for the whole state.
REQ-021 stage_done is ignored in the stage_go cycle; from the following cycle, stage_done=1 -> advance on the next edge.
REQ-022 Stage order SHALL be COMB1, COMB2, COMB3, COMB4, SPLIT4, SPLIT3, SPLIT2, SPLIT1, DONE; a stage never completes in fewer than 2 cycles.
REQ-023 There SHALL be no timeout; a stage waits indefinitely for stage_done.
REQ-024 DONE SHALL last one cycle with code_valid=1, then go to IDLE.
REQ-025 CNT1..CNT6 and sym_err SHALL hold their values from CNT_OUT until the next frame starts in IDLE.
REQ-026 gray_valid in any state other than IDLE/READ SHALL be ignored.
REQ-027 CNT_valid, stage_go and code_valid SHALL be mutually exclusive and registered.

Reset
REQ-028 Reset SHALL force state IDLE; CNT1..CNT6=0; CNT_valid, stage_go, code_valid, busy, sym_err=0; stage_id=0.
REQ-029 Reset asserted mid-frame or mid-stage SHALL abort immediately, with no pulse emitted during or after reset.

Structure
REQ-030 Package huffman_pkg SHALL hold the state enumeration, the stage_id constants (STG_NONE, STG_C1..STG_C4, STG_S4..STG_S1), NUM_SYM=6, and CNT_MAX=255.
REQ-031 A sub-module sym_histogram SHALL implement the six saturating counters and illegal-symbol detection; huffman_seq SHALL hold the FSM.

Verification
REQ-032 Frame 1,1,2,3,3,3,6 then gray_valid=0; stage_done 2 cycles after each go -> CNT=2,1,3,0,0,1; CNT_valid one cycle; eight go pulses with stage_id 1,2,3,4,5,6,7,8; code_valid once.
REQ-033 300 consecutive samples of 4 -> CNT4=255 (saturated), others 0, sym_err=0.
REQ-034 Frame 5,0,9,5 -> CNT5=2, sym_err=1; next frame 2 -> CNT2=1, sym_err=0.
REQ-035 stage_done held high continuously -> each stage lasts exactly 2 cycles; DONE is reached 16 cycles after CNT_OUT.
REQ-036 Reset asserted during COMB3 -> all outputs 0 and state IDLE; a new frame 6 after reset -> CNT6=1 with a full stage sequence.
REQ-037 gray_valid=1 during SPLIT2 with data 1 -> counters unchanged, sequence completes normally.
